stream_scheduler: RTL

Clocked, synthesizable scheduler that decides which of the two processor buffers each of the four input streams feeds. It tracks a decaying per-stream load estimate and the buffer fill levels. At a controlled rate it moves the heaviest stream onto the least-full buffer, and it drives the per-stream select lines of the stream switchers. It replaces the combinational load/destination/register-gate chain between the sources and the switchers.

---
 rtl/processor_sharing_pkg.sv | 26 ++
 rtl/load_tracker.sv | 31 +++
 rtl/stream_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/processor_sharing_pkg.sv
// Shared constants and types for the stream scheduler: stream/buffer sizing,
// hold timing and the scheduler state encoding.
package processor_sharing_pkg;

  localparam int NSTREAM = 4;
  localparam int LOAD_W  = 6;
  localparam int FILL_W  = 5;
  localparam int DEPTH   = 16;
  localparam int HOLD    = 4;
  localparam int IDX_W   = $clog2(NSTREAM);
  localparam int HOLD_W  = $clog2(HOLD);

  // Sized copies so comparisons and loads stay width-matched.
  localparam logic [FILL_W-1:0] DEPTH_FILL = FILL_W'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef logic [LOAD_W-1:0] load_t;

endpackage

// File: rtl/load_tracker.sv
// Per-stream decaying load estimate: saturating count-up while the stream is
// active, halves every idle cycle.
module load_tracker
  import processor_sharing_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  active,
  output load_t L
);

  load_t r_load;
  logic  w_sat;

  assign w_sat = (r_load == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load <= '0;
    end else if (active) begin
      if (!w_sat) begin
        r_load <= r_load + 1'b1;
      end
    end else begin
      r_load <= r_load >> 1;
    end
  end

  assign L = r_load;

endmodule

// File: rtl/stream_scheduler.sv
// Moves the heaviest input stream onto the least-full processor buffer at a
// rate limited by a hold period; drives the registered per-stream select lines.
module stream_scheduler
  import processor_sharing_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NSTREAM-1:0]             active,
  input  logic [FILL_W-1:0]              fill0,
  input  logic [FILL_W-1:0]              fill1,
  output logic [NSTREAM-1:0]             sel,
  output logic                           reassign,
  output logic [IDX_W-1:0]               heavy_idx,
  output state_t                         dbg_state,
  output logic [NSTREAM-1:0][LOAD_W-1:0] dbg_load
);

  function automatic logic [IDX_W-1:0] heaviest(
    input logic [NSTREAM-1:0][LOAD_W-1:0] loads
  );
    logic [IDX_W-1:0]  idx;
    logic [LOAD_W-1:0] best;
    idx  = '0;
    best = loads[0];
    // Strict greater-than keeps the lowest index on ties.
    for (int i = 1; i < NSTREAM; i++) begin
      if (loads[i] > best) begin
        best = loads[i];
        idx  = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic least_full(
    input logic [FILL_W-1:0] f0,
    input logic [FILL_W-1:0] f1
  );
    return (f0 <= f1) ? 1'b0 : 1'b1;
  endfunction

  logic [NSTREAM-1:0][LOAD_W-1:0] w_load;
  logic [IDX_W-1:0]               w_heavy;
  logic                           w_tgt;
  logic [FILL_W-1:0]              w_tgt_fill;
  logic                           w_all_zero;
  logic                           w_move;

  state_t              r_state;
  logic [NSTREAM-1:0]  r_sel;
  logic                r_reassign;
  logic [IDX_W-1:0]    r_heavy;
  logic [HOLD_W-1:0]   r_hold;

  for (genvar g = 0; g < NSTREAM; g++) begin : g_track
    load_tracker u_track (
      .clk    (clk),
      .rst    (rst),
      .active (active[g]),
      .L      (w_load[g])
    );
  end

  assign w_heavy    = heaviest(w_load);
  assign w_tgt      = least_full(fill0, fill1);
  assign w_tgt_fill = w_tgt ? fill1 : fill0;
  assign w_all_zero = (w_load == '0);
  // Fill levels at or above capacity count as full, so no move onto them.
  assign w_move     = (r_sel[w_heavy] != w_tgt) && (w_tgt_fill < DEPTH_FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_reassign <= 1'b0;
      r_heavy    <= '0;
      r_hold     <= '0;
    end else begin
      r_reassign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_all_zero) begin
            r_state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (w_all_zero) begin
            r_state <= ST_IDLE;
          end else if (w_move) begin
            r_sel[w_heavy] <= w_tgt;
            r_heavy        <= w_heavy;
            r_reassign     <= 1'b1;
            r_state        <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_hold  <= HOLD_LOAD;
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_hold == '0) begin
            r_state <= ST_EVAL;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel       = r_sel;
  assign reassign  = r_reassign;
  assign heavy_idx = r_heavy;
  assign dbg_state = r_state;
  assign dbg_load  = w_load;

endmodule
